// File: rtl/vending_machine_multi.sv
// vending_machine_multi: N-product vending controller (1/2/5 coins, credit ceiling, refund, greedy change).
// Define VM_TIMEOUT_EN to make an idle COLLECT period of TIMEOUT_CYC cycles act as cancel.
module vending_machine_multi #(
  parameter int N_PROD = 4,
  parameter int CREDIT_W = 8,
  parameter logic [N_PROD*CREDIT_W-1:0] PRICES = {8'd5, 8'd3, 8'd2, 8'd1},
  parameter int MAX_CREDIT = 20,
  parameter int TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [2:0]          coin_in,
  input  logic [N_PROD-1:0]   sel,
  input  logic                cancel,
  input  logic                change_ready,
  output logic [CREDIT_W-1:0] credit,
  output logic [N_PROD-1:0]   selected,
  output logic                vend,
  output logic                coin_reject,
  output logic                change_valid,
  output logic [2:0]          change_out,
  output logic                busy
);
  typedef enum logic [1:0] {IDLE, COLLECT, VEND, CHANGE} state_t;
  state_t state, state_n;
  logic [CREDIT_W-1:0] credit_n, price, coin_val, chg_val;
  logic [CREDIT_W:0] coin_sum;
  logic [N_PROD-1:0] selected_n;
  logic sel_ok, coin_take, vend_go, timeout;
  assign coin_val = coin_in == 3'b001 ? CREDIT_W'(1) : coin_in == 3'b010 ? CREDIT_W'(2) :
                    coin_in == 3'b100 ? CREDIT_W'(5) : '0;
  assign coin_sum = {1'b0, credit} + {1'b0, coin_val};
  assign sel_ok = $onehot(sel);
  assign busy = state == VEND || state == CHANGE;
  assign change_valid = state == CHANGE;
  assign change_out = !change_valid ? 3'b000 : credit >= CREDIT_W'(5) ? 3'b100 :
                      credit >= CREDIT_W'(2) ? 3'b010 : 3'b001;
  assign chg_val = change_out[2] ? CREDIT_W'(5) : change_out[1] ? CREDIT_W'(2) : CREDIT_W'(1);
  assign vend_go = state == COLLECT && |selected && credit >= price;
  always_comb begin
    price = '0;
    for (int i = 0; i < N_PROD; i++)
      if (selected[i]) price = PRICES[i*CREDIT_W +: CREDIT_W];
  end
`ifdef VM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] idle_cnt;
  assign timeout = state == COLLECT && idle_cnt == TW'(TIMEOUT_CYC - 1);
  always_ff @(posedge clk or negedge reset)
    if (!reset) idle_cnt <= '0;
    else idle_cnt <= (state_n != COLLECT || coin_take || sel_ok) ? '0 : idle_cnt + 1'b1;
`else
  assign timeout = 1'b0;
`endif
  always_comb begin
    state_n = state;
    credit_n = credit;
    selected_n = selected;
    coin_take = 1'b0;
    case (state)
      IDLE, COLLECT: begin
        if (state == COLLECT && (cancel || timeout)) begin
          state_n = credit == '0 ? IDLE : CHANGE;
          selected_n = '0;
        end else begin
          // selection is frozen once the vend decision is taken on the registered values
          if (sel_ok && !vend_go) selected_n = sel;
          coin_take = coin_val != '0 && coin_sum <= (CREDIT_W+1)'(MAX_CREDIT);
          if (coin_take) credit_n = coin_sum[CREDIT_W-1:0];
          state_n = vend_go ? VEND : (coin_take || sel_ok) ? COLLECT : state;
        end
      end
      VEND: begin
        credit_n = credit - price;
        selected_n = '0;
        state_n = credit != price ? CHANGE : IDLE;
      end
      default: if (change_ready) begin
        credit_n = credit - chg_val;
        if (credit == chg_val) state_n = IDLE;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset)
    if (!reset) begin
      state <= IDLE;
      credit <= '0;
      selected <= '0;
      vend <= 1'b0;
      coin_reject <= 1'b0;
    end else begin
      state <= state_n;
      credit <= credit_n;
      selected <= selected_n;
      vend <= state_n == VEND;
      coin_reject <= |coin_in && !coin_take;
    end
endmodule

// File: tb/tb_vending_machine_multi.sv
// tb_vending_machine_multi: directed stimulus; vend/reject/change events checked against a queue of expected events.
module tb_vending_machine_multi;
  logic clk = 0, reset = 0, cancel = 0, change_ready = 0;
  logic [2:0] coin_in = 0;
  logic [3:0] sel = 0;
  logic [7:0] credit;
  logic [3:0] selected;
  logic vend, coin_reject, change_valid, busy;
  logic [2:0] change_out;
  int tests = 0, fails = 0;
  typedef struct {int kind; int value;} ev_t;
  ev_t q[$];
  always #5 clk = ~clk;
  vending_machine_multi dut (
    .clk(clk), .reset(reset), .coin_in(coin_in), .sel(sel), .cancel(cancel),
    .change_ready(change_ready), .credit(credit), .selected(selected), .vend(vend),
    .coin_reject(coin_reject), .change_valid(change_valid), .change_out(change_out), .busy(busy)
  );
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask
  task automatic push(input int k, input int v);
    ev_t e;
    e.kind = k;
    e.value = v;
    q.push_back(e);
  endtask
  task automatic expect_ev(input int k, input logic [31:0] v);
    ev_t e;
    if (q.size() == 0) check("unexpected_event_kind", k, 99);
    else begin
      e = q.pop_front();
      check("event_kind", k, e.kind);
      check("event_value", v, e.value);
    end
  endtask
  // kinds: 0 vend (credit during vend), 1 coin_reject (credit), 2 change coin taken (change_out)
  always @(negedge clk) if (reset) begin
    if (vend) expect_ev(0, credit);
    if (coin_reject) expect_ev(1, credit);
    if (change_valid && change_ready) expect_ev(2, change_out);
  end
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic coin(input logic [2:0] c);
    coin_in = c;
    cyc();
    coin_in = 0;
  endtask
  task automatic pulse_sel(input logic [3:0] s);
    sel = s;
    cyc();
    sel = 0;
  endtask
  task automatic pulse_cancel();
    cancel = 1;
    cyc();
    cancel = 0;
  endtask
  task automatic wait_not_busy(input string name, input int lim);
    int n = 0;
    while (busy && n < lim) begin
      cyc();
      n++;
    end
    check(name, busy, 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end
  initial begin
    int bad;
    #12;
    check("reset_outputs", {credit, selected, vend, coin_reject, change_valid, change_out, busy}, 0);
    @(posedge clk);
    #1 reset = 1;
    cyc();
    pulse_sel(4'b0110);
    check("multihot_sel_ignored", {busy, selected, credit}, 0);
    pulse_cancel();
    check("cancel_idle_ignored", {busy, change_valid, credit}, 0);
    // T2: exact payment
    pulse_sel(4'b0010);
    check("t2_selected", selected, 4'b0010);
    coin(3'b001);
    check("t2_credit1", credit, 1);
    push(0, 2);
    coin(3'b001);
    check("t2_credit2", credit, 2);
    cyc();
    check("t2_vend", {vend, busy}, 2'b11);
    cyc();
    check("t2_after", {credit, vend, busy, change_valid, selected}, 0);
    // T3: overpay, one change coin of 2
    change_ready = 1;
    push(0, 5);
    push(2, 3'b010);
    coin(3'b100);
    pulse_sel(4'b0100);
    cyc();
    check("t3_vend", vend, 1);
    wait_not_busy("t3_idle_timeout", 10);
    check("t3_after", {credit, selected, change_valid}, 0);
    // T4: ceiling and malformed coin
    change_ready = 0;
    repeat (4) coin(3'b100);
    check("t4_credit20", credit, 20);
    push(1, 20);
    coin(3'b001);
    check("t4_over_credit", credit, 20);
    push(1, 20);
    coin(3'b011);
    check("t4_multihot_credit", credit, 20);
    change_ready = 1;
    repeat (4) push(2, 3'b100);
    pulse_cancel();
    wait_not_busy("t4_refund_timeout", 20);
    check("t4_after", credit, 0);
    // T5: refund with a stalled dispenser; coin during CHANGE is rejected
    change_ready = 0;
    coin(3'b100);
    coin(3'b010);
    check("t5_credit7", credit, 7);
    pulse_cancel();
    push(1, 7);
    for (int i = 0; i < 3; i++) begin
      check("t5_hold", {change_valid, change_out, credit}, {1'b1, 3'b100, 8'd7});
      if (i == 0) coin_in = 3'b001;
      cyc();
      coin_in = 0;
    end
    push(2, 3'b100);
    push(2, 3'b010);
    change_ready = 1;
    wait_not_busy("t5_idle_timeout", 10);
    check("t5_after", {credit, change_valid}, 0);
    // T6: without timeout the credit is held
    change_ready = 0;
    coin(3'b010);
    bad = 0;
    repeat (100) begin
      cyc();
      if (credit !== 2 || change_valid !== 0 || busy !== 0) bad++;
    end
    check("t6_hold_cycles_bad", bad, 0);
    change_ready = 1;
    push(2, 3'b010);
    pulse_cancel();
    wait_not_busy("t6_refund_timeout", 10);
    // T1: reset mid-CHANGE
    change_ready = 0;
    coin(3'b010);
    coin(3'b001);
    pulse_cancel();
    check("t1_in_change", {change_valid, change_out, credit}, {1'b1, 3'b010, 8'd3});
    #2 reset = 0;
    #1 check("t1_reset_outputs", {credit, selected, vend, coin_reject, change_valid, change_out, busy}, 0);
    @(posedge clk);
    #1 reset = 1;
    cyc();
    check("t1_after_release", {credit, selected, vend, coin_reject, change_valid, change_out, busy}, 0);
    repeat (3) cyc();
    check("queue_empty", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
